// File: rtl/kem_keygen_if.sv
// Command channel between the keygen sequencer and the polynomial engine.
// The sequencer owns the opcode/slot/param fields and the issue strobe;
// the engine answers each issued op with a single-cycle completion pulse.
interface kem_keygen_if;
   logic [3:0] cmd_op;
   logic [4:0] cmd_slot_a;
   logic [4:0] cmd_slot_b;
   logic [3:0] cmd_param;
   logic       cmd_start;
   logic       cmd_done;

   modport master (
      output cmd_op, cmd_slot_a, cmd_slot_b, cmd_param, cmd_start,
      input  cmd_done
   );

   modport slave (
      input  cmd_op, cmd_slot_a, cmd_slot_b, cmd_param, cmd_start,
      output cmd_done
   );
endinterface

// File: rtl/kem_keygen_seq.sv
// ML-KEM key-generation sequencer. Walks the full keygen micro-op list
// (CBD, NTT, basemul, accumulate) for rank K, issuing one op at a time to
// an external polynomial engine, and gates host writes to the engine's
// polynomial bank while a run is in flight.
module kem_keygen_seq #(
   parameter int K    = 3,
   parameter int ETA1 = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [5:0]   op_count,
   kem_keygen_if.master cmd,
   input  logic         host_we,
   output logic         eng_host_we,
   output logic         host_err
);

   // Slot map: A_hat[i][j] at i*K+j, then the K s slots, then the K e slots.
   localparam int         S_BASE  = K * K;
   localparam int         E_BASE  = K * K + K;
   localparam int         NOPS    = 2 * K * K + 4 * K;
   localparam logic [1:0] KM1     = 2'(K - 1);
   localparam logic [5:0] LAST_OP = 6'(NOPS - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

   // Sections of the op list, in issue order.
   typedef enum logic [2:0] {
      PH_CBD_S, PH_CBD_E, PH_NTT_S, PH_NTT_E, PH_BMUL, PH_ADD_ROW, PH_ADD_E
   } phase_e;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0, OP_CBD = 4'd1, OP_NTT = 4'd2, OP_BMUL = 4'd3, OP_ADD = 4'd4
   } op_e;

   typedef struct packed {
      op_e        op;
      logic [4:0] a;
      logic [4:0] b;
      logic [3:0] param;
   } cmd_t;

   state_e     state_q, state_d;
   phase_e     phase_q, phase_d, adv_phase;
   logic [1:0] i_q, i_d, adv_i;
   logic [1:0] j_q, j_d, adv_j;
   cmd_t       cmd_q, cmd_d;
   logic [5:0] op_count_q, op_count_d;
   logic       abort_q, abort_d;
   logic       host_err_q, host_err_d;
   logic       done_q, done_d;
   logic       aborted_q, aborted_d;
   logic       load_first, load_next, fin_done, fin_abort;
   logic       cmd_start_w;

   // Command word for a given position (phase, row i, column j) in the list.
   function automatic cmd_t decode(phase_e ph, logic [1:0] i, logic [1:0] j);
      cmd_t       c;
      logic [4:0] ii, jj, row;
      ii  = {3'b000, i};
      jj  = {3'b000, j};
      row = 5'(ii * 5'(K));
      c   = '0;
      case (ph)
         PH_CBD_S:   begin c.op = OP_CBD;  c.a = 5'(S_BASE) + jj; c.param = 4'(ETA1); end
         PH_CBD_E:   begin c.op = OP_CBD;  c.a = 5'(E_BASE) + jj; c.param = 4'(ETA1); end
         PH_NTT_S:   begin c.op = OP_NTT;  c.a = 5'(S_BASE) + jj; end
         PH_NTT_E:   begin c.op = OP_NTT;  c.a = 5'(E_BASE) + jj; end
         PH_BMUL:    begin c.op = OP_BMUL; c.a = row + jj; c.b = 5'(S_BASE) + jj; end
         PH_ADD_ROW: begin c.op = OP_ADD;  c.a = row; c.b = row + jj; end
         PH_ADD_E:   begin c.op = OP_ADD;  c.a = row; c.b = 5'(E_BASE) + ii; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   // State register.
   // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and run-level events.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      load_next  = 1'b0;
      fin_done   = 1'b0;
      fin_abort  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = ISSUE;
               load_first = 1'b1;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (cmd.cmd_done) begin
               if (op_count_q == LAST_OP) begin
                  state_d  = IDLE;
                  fin_done = 1'b1;
               end else if (abort_q) begin
                  state_d   = IDLE;
                  fin_abort = 1'b1;
               end else begin
                  state_d   = ISSUE;
                  load_next = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      busy        = (state_q != IDLE);
      cmd_start_w = (state_q == ISSUE);
      eng_host_we = host_we & ~busy;
   end

   // Position of the op after the current one: j inner, i outer per section.
   always_comb begin
      adv_phase = phase_q;
      adv_i     = i_q;
      adv_j     = j_q;
      case (phase_q)
         PH_CBD_S, PH_CBD_E, PH_NTT_S, PH_NTT_E: begin
            if (j_q == KM1) begin
               adv_phase = phase_e'(phase_q + 3'd1);
               adv_j     = 2'd0;
            end else begin
               adv_j = j_q + 2'd1;
            end
         end
         PH_BMUL: begin
            if (j_q != KM1) begin
               adv_j = j_q + 2'd1;
            end else if (i_q != KM1) begin
               adv_i = i_q + 2'd1;
               adv_j = 2'd0;
            end else begin
               // Row accumulation skips column 0, which is the accumulator itself.
               adv_phase = PH_ADD_ROW;
               adv_i     = 2'd0;
               adv_j     = 2'd1;
            end
         end
         PH_ADD_ROW: begin
            if (j_q != KM1) begin
               adv_j = j_q + 2'd1;
            end else if (i_q != KM1) begin
               adv_i = i_q + 2'd1;
               adv_j = 2'd1;
            end else begin
               adv_phase = PH_ADD_E;
               adv_i     = 2'd0;
               adv_j     = 2'd0;
            end
         end
         default: adv_i = i_q + 2'd1;
      endcase
   end

   // Datapath next values: list position, command word, counters and flags.
   always_comb begin
      phase_d    = phase_q;
      i_d        = i_q;
      j_d        = j_q;
      cmd_d      = cmd_q;
      op_count_d = op_count_q;
      abort_d    = abort_q;
      host_err_d = host_err_q;
      done_d     = fin_done;
      aborted_d  = fin_abort;
      if (load_first) begin
         phase_d    = PH_CBD_S;
         i_d        = 2'd0;
         j_d        = 2'd0;
         op_count_d = 6'd0;
         abort_d    = 1'b0;
         host_err_d = 1'b0;
      end else if (load_next) begin
         phase_d = adv_phase;
         i_d     = adv_i;
         j_d     = adv_j;
      end
      if (load_first || load_next) cmd_d = decode(phase_d, i_d, j_d);
      if (state_q == WAIT && cmd.cmd_done) op_count_d = op_count_q + 6'd1;
      if (busy && abort)   abort_d    = 1'b1;
      if (busy && host_we) host_err_d = 1'b1;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= PH_CBD_S;
         i_q        <= 2'd0;
         j_q        <= 2'd0;
         cmd_q      <= '0;
         op_count_q <= 6'd0;
         abort_q    <= 1'b0;
         host_err_q <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         i_q        <= i_d;
         j_q        <= j_d;
         cmd_q      <= cmd_d;
         op_count_q <= op_count_d;
         abort_q    <= abort_d;
         host_err_q <= host_err_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
      end
   end

   assign done           = done_q;
   assign aborted        = aborted_q;
   assign op_count       = op_count_q;
   assign host_err       = host_err_q;
   assign cmd.cmd_op     = cmd_q.op;
   assign cmd.cmd_slot_a = cmd_q.a;
   assign cmd.cmd_slot_b = cmd_q.b;
   assign cmd.cmd_param  = cmd_q.param;
   assign cmd.cmd_start  = cmd_start_w;

endmodule
